uart_controller: RTL

Memory-mapped 8N1 UART peripheral on the CPU data bus, selected by the address decoder's UART chip-select. It occupies the slot beside the timer and GPIO blocks.
- CPU writes bytes into an 8-entry TX FIFO, which a serializer shifts out on TXD.
- A deserializer samples RXD into a single holding register.
- Status and interrupt-enable bits are exposed through a 4-word register window.

---
 rtl/uart_pkg.sv | 48 ++++
 rtl/uart_tx_fifo.sv | 54 +++++
 rtl/uart_controller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped 8N1 UART: register offsets,
// STATUS/CTRL bit positions, FSM encodings and the CTRL register layout.
package uart_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DIV_W    = 16;
  localparam int unsigned TX_DEPTH = 8;
  localparam int unsigned TX_AW    = 3;

  localparam logic [DIV_W-1:0] DIV_RESET = 16'd433;

  // Word offsets decoded from Addr[3:2]
  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_RXDATA = 2'd1;
  localparam logic [1:0] UART_STATUS = 2'd2;
  localparam logic [1:0] UART_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int unsigned ST_RXVALID  = 0;
  localparam int unsigned ST_TXFULL   = 1;
  localparam int unsigned ST_TXEMPTY  = 2;
  localparam int unsigned ST_TXBUSY   = 3;
  localparam int unsigned ST_OVERRUN  = 4;
  localparam int unsigned ST_FRAMEERR = 5;

  // CTRL bit positions above the divisor field
  localparam int unsigned CTRL_RXIE = 16;
  localparam int unsigned CTRL_TXIE = 17;
  localparam int unsigned CTRL_LOOP = 18;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  typedef struct packed {
    logic             txie;
    logic             rxie;
    logic [DIV_W-1:0] div;
  } ctrl_t;

  // Reload value giving (div+1)/2 clocks before the mid-start resample
  function automatic logic [DIV_W-1:0] rx_half_load(input logic [DIV_W-1:0] div);
    logic [DIV_W:0] half;
    half = (17'(div) + 17'd1) >> 1;
    return (half == 17'd0) ? 16'd0 : 16'(half - 17'd1);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO; a push into a full FIFO is dropped even if a pop
// happens on the same edge.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = TX_DEPTH,
  parameter int unsigned AW    = TX_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_controller.sv
// Memory-mapped 8N1 UART: TX FIFO + serializer, RX deserializer with a single
// holding register, STATUS/CTRL window and a level interrupt.
// Optional loopback (CTRL[18]) is built only when UART_LOOPBACK_EN is defined.
module uart_controller
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              CS_N,
  input  logic              RD_N,
  input  logic              WR_N,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Intr,
  input  logic              RXD,
  output logic              TXD
);

  logic [1:0] sel;
  logic       wr_en, rd_en, rx_pop, status_wr;
  ctrl_t      ctrl_q;
  logic       loop_q;

  logic       fifo_push, fifo_pop_c, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  logic [TX_AW:0] fifo_count;

  tx_state_e        tx_state_q, tx_state_n;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_n;
  logic [2:0]       tx_bit_q, tx_bit_n;
  logic [7:0]       tx_shift_q, tx_shift_n;
  logic             tx_line_q, tx_line_n, tx_busy;

  rx_state_e        rx_state_q, rx_state_n;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_n;
  logic [2:0]       rx_bit_q, rx_bit_n;
  logic [7:0]       rx_shift_q, rx_shift_n, rx_byte_q;
  logic             sync1_q, sync2_q, rx_in, rx_prev_q, stop_ev_c;
  logic             rxvalid_q, overrun_q, frameerr_q;

  logic             unused_bits;

  assign sel       = Addr[3:2];
  assign wr_en     = !CS_N && !WR_N;
  assign rd_en     = !CS_N && !RD_N;
  assign fifo_push = wr_en && (sel == UART_TXDATA);
  assign rx_pop    = wr_en && (sel == UART_RXDATA);
  assign status_wr = wr_en && (sel == UART_STATUS);
  assign tx_busy   = (tx_state_q != TX_IDLE);
  assign unused_bits = ^{Addr[11:4], Addr[1:0], DataIn[31:16], fifo_count};

  uart_tx_fifo #(.DEPTH(TX_DEPTH), .AW(TX_AW)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (DataIn[7:0]),
    .pop   (fifo_pop_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // CTRL register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '{txie: 1'b0, rxie: 1'b0, div: DIV_RESET};
    end else if (wr_en && (sel == UART_CTRL)) begin
      ctrl_q.div  <= DataIn[DIV_W-1:0];
      ctrl_q.rxie <= DataIn[CTRL_RXIE];
      ctrl_q.txie <= DataIn[CTRL_TXIE];
    end
  end

`ifdef UART_LOOPBACK_EN
  // Loopback enable bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            loop_q <= 1'b0;
    else if (wr_en && (sel == UART_CTRL))  loop_q <= DataIn[CTRL_LOOP];
  end
  assign rx_in = loop_q ? tx_line_q : sync2_q;
`else
  assign loop_q = 1'b0;
  assign rx_in  = sync2_q;
`endif

  // TX state register and serial line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      TXD        <= 1'b1;
    end else begin
      tx_state_q <= tx_state_n;
      tx_cnt_q   <= tx_cnt_n;
      tx_bit_q   <= tx_bit_n;
      tx_shift_q <= tx_shift_n;
      tx_line_q  <= tx_line_n;
      TXD        <= loop_q ? 1'b1 : tx_line_n;
    end
  end

  // TX next state; each state lasts div+1 clocks, frames chain with no gap
  always_comb begin
    tx_state_n = tx_state_q;
    tx_cnt_n   = tx_cnt_q;
    tx_bit_n   = tx_bit_q;
    tx_shift_n = tx_shift_q;
    fifo_pop_c = 1'b0;
    tx_line_n  = 1'b1;
    case (tx_state_q)
      TX_IDLE: if (!fifo_empty) begin
        fifo_pop_c = 1'b1;
        tx_shift_n = fifo_dout;
        tx_cnt_n   = ctrl_q.div;
        tx_state_n = TX_START;
      end
      TX_START: if (tx_cnt_q == '0) begin
        tx_cnt_n   = ctrl_q.div;
        tx_bit_n   = 3'd0;
        tx_state_n = TX_DATA;
      end else tx_cnt_n = tx_cnt_q - 16'd1;
      TX_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_n = ctrl_q.div;
        if (tx_bit_q == 3'd7) tx_state_n = TX_STOP;
        else begin
          tx_bit_n   = tx_bit_q + 3'd1;
          tx_shift_n = tx_shift_q >> 1;
        end
      end else tx_cnt_n = tx_cnt_q - 16'd1;
      TX_STOP: if (tx_cnt_q == '0) begin
        if (!fifo_empty) begin
          fifo_pop_c = 1'b1;
          tx_shift_n = fifo_dout;
          tx_cnt_n   = ctrl_q.div;
          tx_state_n = TX_START;
        end else tx_state_n = TX_IDLE;
      end else tx_cnt_n = tx_cnt_q - 16'd1;
      default: tx_state_n = TX_IDLE;
    endcase
    case (tx_state_n)
      TX_START: tx_line_n = 1'b0;
      TX_DATA:  tx_line_n = tx_shift_n[0];
      default:  tx_line_n = 1'b1;
    endcase
  end

  // RX synchronizer and FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      sync1_q    <= RXD;
      sync2_q    <= sync1_q;
      rx_prev_q  <= rx_in;
      rx_state_q <= rx_state_n;
      rx_cnt_q   <= rx_cnt_n;
      rx_bit_q   <= rx_bit_n;
      rx_shift_q <= rx_shift_n;
    end
  end

  // RX next state: mid-bit sampling after a falling edge
  always_comb begin
    rx_state_n = rx_state_q;
    rx_cnt_n   = rx_cnt_q;
    rx_bit_n   = rx_bit_q;
    rx_shift_n = rx_shift_q;
    stop_ev_c  = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_in) begin
        rx_cnt_n   = rx_half_load(ctrl_q.div);
        rx_state_n = RX_START;
      end
      RX_START: if (rx_cnt_q == '0) begin
        rx_cnt_n   = ctrl_q.div;
        rx_bit_n   = 3'd0;
        rx_state_n = rx_in ? RX_IDLE : RX_DATA;
      end else rx_cnt_n = rx_cnt_q - 16'd1;
      RX_DATA: if (rx_cnt_q == '0) begin
        rx_cnt_n   = ctrl_q.div;
        rx_shift_n = {rx_in, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_n = RX_STOP;
        else                  rx_bit_n   = rx_bit_q + 3'd1;
      end else rx_cnt_n = rx_cnt_q - 16'd1;
      RX_STOP: if (rx_cnt_q == '0) begin
        stop_ev_c  = 1'b1;
        rx_state_n = RX_IDLE;
      end else rx_cnt_n = rx_cnt_q - 16'd1;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // RX holding register and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_byte_q  <= '0;
      rxvalid_q  <= 1'b0;
      overrun_q  <= 1'b0;
      frameerr_q <= 1'b0;
    end else begin
      if (stop_ev_c && rx_in) begin
        if (!rxvalid_q || rx_pop) begin
          rx_byte_q <= rx_shift_q;
          rxvalid_q <= 1'b1;
        end else overrun_q <= 1'b1;
      end else if (rx_pop) rxvalid_q <= 1'b0;
      if (status_wr && DataIn[ST_OVERRUN] && !(stop_ev_c && rx_in && rxvalid_q && !rx_pop))
        overrun_q <= 1'b0;
      if (stop_ev_c && !rx_in)                    frameerr_q <= 1'b1;
      else if (status_wr && DataIn[ST_FRAMEERR])  frameerr_q <= 1'b0;
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) Intr <= 1'b0;
    else        Intr <= (ctrl_q.rxie & rxvalid_q) | (ctrl_q.txie & fifo_empty & ~tx_busy);
  end

  // Combinational read mux, zero when not selected
  always_comb begin
    DataOut = '0;
    if (rd_en) begin
      case (sel)
        UART_RXDATA: DataOut = {24'h0, rx_byte_q};
        UART_STATUS: DataOut = {26'h0, frameerr_q, overrun_q, tx_busy, fifo_empty,
                                fifo_full, rxvalid_q};
        UART_CTRL:   DataOut = {13'h0, loop_q, ctrl_q.txie, ctrl_q.rxie, ctrl_q.div};
        default:     DataOut = '0;
      endcase
    end
  end

endmodule
